// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between NREQ requesters.
// Results return on a single response channel tagged with the requester ID.
module alu_arbiter #(
    parameter int NREQ         = 4,
    parameter int DATA_WIDTH   = 31,
    parameter int OPCODE_WIDTH = 2,
    parameter int IDW          = $clog2(NREQ)
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NREQ-1:0]                  req_valid,
    output logic [NREQ-1:0]                  req_ready,
    input  logic [NREQ*(OPCODE_WIDTH+1)-1:0] req_opcode,
    input  logic [NREQ*(DATA_WIDTH+1)-1:0]   req_op1,
    input  logic [NREQ*(DATA_WIDTH+1)-1:0]   req_op2,
    output logic [OPCODE_WIDTH:0]            alu_opcode,
    output logic [DATA_WIDTH:0]              alu_op1,
    output logic [DATA_WIDTH:0]              alu_op2,
    input  logic [DATA_WIDTH:0]              alu_result,
    input  logic                             alu_carry,
    input  logic                             alu_zero,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [IDW-1:0]                   rsp_id,
    output logic [DATA_WIDTH:0]              rsp_result,
    output logic                             rsp_carry,
    output logic                             rsp_zero,
    output logic                             rsp_err,
    output logic                             busy
);

    localparam int OW = OPCODE_WIDTH + 1;
    localparam int DW = DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] cand;
    logic           grant_hit;
    logic           accept;
    logic           sel_err;
    logic [OW-1:0]  sel_op;
    logic [IDW-1:0] id_q;

    // Search starts just above the last winner and wraps.
    always_comb begin
        grant_id  = '0;
        grant_hit = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NREQ);
            if (!grant_hit && req_valid[cand]) begin
                grant_hit = 1'b1;
                grant_id  = cand;
            end
        end
    end

    assign accept  = (state == IDLE) && grant_hit;
    assign sel_op  = req_opcode[int'(grant_id)*OW +: OW];
    assign sel_err = sel_op > OW'(3);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = sel_err ? RESP : EXEC;
            EXEC: state_nxt = CAPT;
            CAPT: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_id] = 1'b1;
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    // Error requests bypass the ALU and load the response directly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= IDW'(NREQ - 1);
            id_q       <= '0;
            alu_opcode <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (accept) begin
            last_grant <= grant_id;
            id_q       <= grant_id;
            alu_opcode <= sel_op;
            alu_op1    <= req_op1[int'(grant_id)*DW +: DW];
            alu_op2    <= req_op2[int'(grant_id)*DW +: DW];
            if (sel_err) begin
                rsp_result <= '0;
                rsp_carry  <= 1'b0;
                rsp_zero   <= 1'b0;
                rsp_err    <= 1'b1;
            end
        end else if (state == CAPT) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_zero   <= alu_zero;
            rsp_err    <= 1'b0;
        end
    end

    assign rsp_id = id_q;

endmodule
